// File: rtl/keypad_scan_controller.sv
// 4x3 matrix keypad scanner: drives one column at a time, samples the rows at the end of each
// column dwell, debounces whole frames and hands single press events to a ready/valid consumer.
// Optional auto-repeat is built only when the macro KEYPAD_REPEAT_EN is defined.
module keypad_scan_controller #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_DELAY   = 64,
  parameter int unsigned REPEAT_RATE    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] activeRow,
  output logic [2:0] activeColumn,
  output logic [3:0] keyCode,
  output logic       keyValid,
  input  logic       keyReady,
  output logic       keyHeld,
  output logic       overflow
);

  // Candidate codes beyond the 12 real keys.
  localparam logic [3:0] CandNone    = 4'hE;
  localparam logic [3:0] CandInvalid = 4'hF;
  localparam logic [3:0] DebounceTarget = 4'(DEBOUNCE_SCANS);
  localparam logic [15:0] DwellReload   = 16'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : gen_scan_div_check
    $error("SCAN_DIV must be in 2..65535");
  end
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : gen_debounce_check
    $error("DEBOUNCE_SCANS must be in 1..15");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : gen_repeat_check
    $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  typedef enum logic {StReleased, StPressed} state_e;

  state_e      state, stateNext;
  logic [15:0] dwellCount, dwellCountNext;
  logic [2:0]  activeColumnNext;
  logic [3:0]  sampleCol1, sampleCol1Next;
  logic [3:0]  sampleCol2, sampleCol2Next;
  logic [3:0]  prevCand, prevCandNext;
  logic [3:0]  debCount, debCountNext;
  logic [3:0]  keyCodeNext;
  logic        keyValidNext;
  logic        overflowNext;

  logic        dwellEnd;
  logic        frameEnd;
  logic [11:0] frameHits;
  logic [3:0]  hitCount;
  logic [3:0]  hitKey;
  logic [3:0]  candidate;
  logic        pressPush;
  logic        repeatPush;
  logic        eventPush;

  assign keyHeld = (state == StPressed);

  // Column rotation and row sampling at the last cycle of each dwell.
  always_comb begin
    dwellEnd         = (dwellCount == 16'd0);
    frameEnd         = dwellEnd && activeColumn[2];
    dwellCountNext   = dwellCount - 16'd1;
    activeColumnNext = activeColumn;
    sampleCol1Next   = sampleCol1;
    sampleCol2Next   = sampleCol2;
    if (dwellEnd) begin
      dwellCountNext   = DwellReload;
      activeColumnNext = {activeColumn[1:0], activeColumn[2]};
      if (activeColumn[0]) sampleCol1Next = activeRow;
      if (activeColumn[1]) sampleCol2Next = activeRow;
    end
  end

  // Frame candidate: a key only when exactly one row bit was seen across the whole frame.
  always_comb begin
    frameHits = {activeRow, sampleCol2, sampleCol1};
    hitCount  = 4'($countones(frameHits));
    hitKey    = CandNone;
    for (int i = 0; i < 12; i++) begin
      if (frameHits[i]) begin
        case (i)
          0:       hitKey = 4'hB;
          1:       hitKey = 4'h9;
          2:       hitKey = 4'h6;
          3:       hitKey = 4'h3;
          4:       hitKey = 4'h0;
          5:       hitKey = 4'h8;
          6:       hitKey = 4'h5;
          7:       hitKey = 4'h2;
          8:       hitKey = 4'hA;
          9:       hitKey = 4'h7;
          10:      hitKey = 4'h4;
          default: hitKey = 4'h1;
        endcase
      end
    end
    if (hitCount == 4'd0)      candidate = CandNone;
    else if (hitCount == 4'd1) candidate = hitKey;
    else                       candidate = CandInvalid;
  end

  // Debounce counter and press/release state machine, evaluated once per frame.
  always_comb begin
    stateNext    = state;
    prevCandNext = prevCand;
    debCountNext = debCount;
    pressPush    = 1'b0;
    if (frameEnd) begin
      prevCandNext = candidate;
      if (candidate == prevCand) begin
        debCountNext = (debCount == 4'hF) ? 4'hF : debCount + 4'd1;
      end else begin
        debCountNext = 4'd1;
      end
      unique case (state)
        StReleased: begin
          if (candidate <= 4'hB && debCountNext == DebounceTarget) begin
            stateNext = StPressed;
            pressPush = 1'b1;
          end
        end
        StPressed: begin
          if (candidate == CandNone && debCountNext == DebounceTarget) begin
            stateNext = StReleased;
          end
        end
        default: stateNext = StReleased;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [3:0]  pressedKey, pressedKeyNext;
  logic [15:0] repeatCount, repeatCountNext;

  // Count frames down to the next auto-repeat while the same key stays down.
  always_comb begin
    pressedKeyNext  = pressedKey;
    repeatCountNext = repeatCount;
    repeatPush      = 1'b0;
    if (pressPush) begin
      pressedKeyNext  = candidate;
      repeatCountNext = 16'(REPEAT_DELAY);
    end else if (frameEnd && state == StPressed && candidate == pressedKey) begin
      if (repeatCount <= 16'd1) begin
        repeatPush      = 1'b1;
        repeatCountNext = 16'(REPEAT_RATE);
      end else begin
        repeatCountNext = repeatCount - 16'd1;
      end
    end
  end

  // Repeat bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pressedKey  <= CandNone;
      repeatCount <= 16'd0;
    end else begin
      pressedKey  <= pressedKeyNext;
      repeatCount <= repeatCountNext;
    end
  end
`else
  assign repeatPush = 1'b0;
`endif

  // Single-entry event slot; a push into a full, stalled slot is dropped and flagged.
  // A repeat is only issued while candidate equals the held key, so candidate is the code.
  always_comb begin
    eventPush    = pressPush | repeatPush;
    keyValidNext = keyValid;
    keyCodeNext  = keyCode;
    overflowNext = overflow;
    if (eventPush) begin
      if (keyValid && !keyReady) begin
        overflowNext = 1'b1;
      end else begin
        keyValidNext = 1'b1;
        keyCodeNext  = candidate;
      end
    end else if (keyValid && keyReady) begin
      keyValidNext = 1'b0;
      keyCodeNext  = 4'h0;
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      activeColumn <= 3'b001;
      dwellCount   <= DwellReload;
      sampleCol1   <= 4'h0;
      sampleCol2   <= 4'h0;
      prevCand     <= CandNone;
      debCount     <= 4'd0;
      state        <= StReleased;
      keyValid     <= 1'b0;
      keyCode      <= 4'h0;
      overflow     <= 1'b0;
    end else begin
      activeColumn <= activeColumnNext;
      dwellCount   <= dwellCountNext;
      sampleCol1   <= sampleCol1Next;
      sampleCol2   <= sampleCol2Next;
      prevCand     <= prevCandNext;
      debCount     <= debCountNext;
      state        <= stateNext;
      keyValid     <= keyValidNext;
      keyCode      <= keyCodeNext;
      overflow     <= overflowNext;
    end
  end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: a physical keypad model drives the rows from a set of pressed
// keys; a frame-level reference model predicts every output each cycle.
module tb_keypad_scan_controller;

  localparam int unsigned ScanDiv  = 4;
  localparam int unsigned DebScans = 2;
  localparam int unsigned RepDelay = 3;
  localparam int unsigned RepRate  = 2;
  localparam int unsigned FrameLen = 3 * ScanDiv;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  activeRow;
  logic [2:0]  activeColumn;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyReady;
  logic        keyHeld;
  logic        overflow;
  logic [11:0] keyMask;  // bit k set: key with code k is physically down

  int compared   = 0;
  int mismatched = 0;
  int validCycles = 0;

  always #5 clock = ~clock;

  keypad_scan_controller #(
    .SCAN_DIV      (ScanDiv),
    .DEBOUNCE_SCANS(DebScans),
    .REPEAT_DELAY  (RepDelay),
    .REPEAT_RATE   (RepRate)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .activeRow   (activeRow),
    .activeColumn(activeColumn),
    .keyCode     (keyCode),
    .keyValid    (keyValid),
    .keyReady    (keyReady),
    .keyHeld     (keyHeld),
    .overflow    (overflow)
  );

  // Keypad geometry: column index 0=col1, 1=col2, 2=col3; row bit 3=top row.
  function automatic int colOf(input int k);
    case (k)
      3, 6, 9, 11: return 0;
      2, 5, 8, 0:  return 1;
      default:     return 2;
    endcase
  endfunction

  function automatic int rowOf(input int k);
    case (k)
      1, 2, 3: return 3;
      4, 5, 6: return 2;
      7, 8, 9: return 1;
      default: return 0;
    endcase
  endfunction

  // Pressed keys short their row to the driven column.
  always_comb begin
    activeRow = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      if (keyMask[k] && activeColumn[colOf(k)]) activeRow[rowOf(k)] = 1'b1;
    end
  end

  // Reference model state.
  int mCyc;
  int hitCount;
  int hitKey;
  int prevCand;   // -1 none, -2 invalid, else key code
  int runLen;
  bit pressed;
  int heldKey;
  int sinceEvent;
  bit firstRepDone;
  bit mValid;
  int mCode;
  bit mOvf;

  task automatic modelEdge();
    bit push;
    int cand;
    push = 1'b0;
    cand = -1;
    if (reset) begin
      mCyc = 0; hitCount = 0; hitKey = 0; prevCand = -1; runLen = 0;
      pressed = 1'b0; heldKey = -1; sinceEvent = 0; firstRepDone = 1'b0;
      mValid = 1'b0; mCode = 0; mOvf = 1'b0;
      return;
    end
    if (mCyc % ScanDiv == ScanDiv - 1) begin
      for (int k = 0; k < 12; k++) begin
        if (keyMask[k] && colOf(k) == (mCyc / ScanDiv) % 3) begin
          hitCount++;
          hitKey = k;
        end
      end
    end
    if (mCyc % FrameLen == FrameLen - 1) begin
      cand = (hitCount == 0) ? -1 : (hitCount == 1) ? hitKey : -2;
      hitCount = 0;
      runLen = (cand == prevCand) ? ((runLen < 15) ? runLen + 1 : 15) : 1;
      prevCand = cand;
      if (!pressed) begin
        if (cand >= 0 && runLen == DebScans) begin
          pressed = 1'b1; heldKey = cand; push = 1'b1;
          sinceEvent = 0; firstRepDone = 1'b0;
        end
      end else if (cand == -1 && runLen == DebScans) begin
        pressed = 1'b0;
      end
`ifdef KEYPAD_REPEAT_EN
      else if (cand == heldKey) begin
        sinceEvent++;
        if (sinceEvent == (firstRepDone ? RepRate : RepDelay)) begin
          push = 1'b1; sinceEvent = 0; firstRepDone = 1'b1;
        end
      end
`endif
    end
    if (push) begin
      if (mValid && !keyReady) mOvf = 1'b1;
      else begin
        mValid = 1'b1;
        mCode  = cand;
      end
    end else if (mValid && keyReady) begin
      mValid = 1'b0;
      mCode  = 0;
    end
    mCyc++;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic checkAll();
    check("col", int'(activeColumn), 1 << ((mCyc / ScanDiv) % 3));
    check("valid", int'(keyValid), int'(mValid));
    check("code", int'(keyCode), mCode);
    check("held", int'(keyHeld), int'(pressed));
    check("ovf", int'(overflow), int'(mOvf));
  endtask

  task automatic step();
    @(posedge clock);
    modelEdge();
    #1;
    checkAll();
    if (keyValid) validCycles++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic runFrames(input int n);
    runCycles(n * FrameLen);
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [11:0] mask;
    logic        expValid;
    logic [3:0]  expCode;
    logic        expHeld;
  } vec_t;

  vec_t tbl[16];
  logic [2:0] colSeq[13] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010,
                             3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
  int repExp[9] = '{0, 1, 0, 0, 1, 0, 1, 0, 1};

  initial begin
    for (int k = 0; k < 12; k++) begin
      tbl[k] = '{mask: 12'(1 << k), expValid: 1'b1, expCode: 4'(k), expHeld: 1'b1};
    end
    tbl[12] = '{mask: 12'h801, expValid: 1'b0, expCode: 4'h0, expHeld: 1'b0};  // # and 0
    tbl[13] = '{mask: 12'h060, expValid: 1'b0, expCode: 4'h0, expHeld: 1'b0};  // 5 and 6
    tbl[14] = '{mask: 12'h024, expValid: 1'b0, expCode: 4'h0, expHeld: 1'b0};  // 2 and 5
    tbl[15] = '{mask: 12'h00E, expValid: 1'b0, expCode: 4'h0, expHeld: 1'b0};  // 1, 2, 3

    reset = 1'b1;
    keyMask = '0;
    keyReady = 1'b0;
    step();
    doReset();

    // Column sequence right after reset release.
    check("col_seq", int'(activeColumn), int'(colSeq[0]));
    for (int i = 1; i < 13; i++) begin
      step();
      check("col_seq", int'(activeColumn), int'(colSeq[i]));
    end

    // Table: hold a pattern two frames, check the event, consume it, release two frames.
    doReset();
    for (int i = 0; i < 16; i++) begin
      keyMask  = tbl[i].mask;
      keyReady = 1'b0;
      runFrames(2);
      check("tbl_valid", int'(keyValid), int'(tbl[i].expValid));
      check("tbl_code", int'(keyCode), int'(tbl[i].expCode));
      check("tbl_held", int'(keyHeld), int'(tbl[i].expHeld));
      keyMask  = '0;
      keyReady = 1'b1;
      step();
      keyReady = 1'b0;
      runCycles(2 * FrameLen - 1);
      check("tbl_release", int'(keyHeld), 0);
      check("tbl_consumed", int'(keyValid), 0);
    end

    // Stalled consumer: press 5, release, press 9 -> 9 is dropped.
    doReset();
    keyReady = 1'b0;
    keyMask = 12'(1 << 5);
    runFrames(2);
    keyMask = '0;
    runFrames(2);
    keyMask = 12'(1 << 9);
    runFrames(2);
    check("ovf_code", int'(keyCode), 5);
    check("ovf_valid", int'(keyValid), 1);
    check("ovf_flag", int'(overflow), 1);
    keyMask = '0;
    keyReady = 1'b1;
    runFrames(2);
    keyReady = 1'b0;
    check("ovf_sticky", int'(overflow), 1);
    check("ovf_drained", int'(keyValid), 0);

    // Reset in the middle of the col2 dwell while key 4 is debouncing.
    doReset();
    keyMask = 12'(1 << 4);
    runFrames(1);
    runCycles(ScanDiv + 2);
    reset = 1'b1;
    step();
    check("rst_col", int'(activeColumn), 1);
    check("rst_valid", int'(keyValid), 0);
    check("rst_code", int'(keyCode), 0);
    check("rst_held", int'(keyHeld), 0);
    check("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    runFrames(1);
    keyMask = '0;
    runFrames(2);
    check("rst_no_event", int'(keyValid), 0);
    check("rst_no_held", int'(keyHeld), 0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: hold 8 for nine frames, events expected at frames 2, 5, 7, 9.
    doReset();
    keyReady = 1'b1;
    keyMask = 12'(1 << 8);
    for (int f = 0; f < 9; f++) begin
      int before;
      before = validCycles;
      runFrames(1);
      check("repeat_frame", validCycles - before, repExp[f]);
    end
    keyMask = '0;
    runFrames(2);
`endif

    // Random key patterns, random consumer stalls, occasional reset.
    doReset();
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    keyMask = '0;
        2, 3, 4: keyMask = 12'(1 << $urandom_range(0, 11));
        default: keyMask = 12'(1 << $urandom_range(0, 11)) | 12'(1 << $urandom_range(0, 11));
      endcase
      for (int c = 0; c < int'($urandom_range(1, 4)) * FrameLen; c++) begin
        keyReady = ($urandom_range(0, 2) != 0);
        step();
      end
      if ($urandom_range(0, 39) == 0) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
